// File: rtl/dh_pkg.sv
// Shared types and defaults for the Diffie-Hellman R1 responder.
package dh_pkg;

  localparam int DEF_DW      = 32;
  localparam int DEF_KW      = 4;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    SQR     = 3'd2,
    MUL     = 3'd3,
    NEXT    = 3'd4,
    SEND_C1 = 3'd5,
    WAIT_C2 = 3'd6,
    DONE    = 3'd7
  } dh_state_t;

  typedef struct packed {
    logic start;
    logic done;
  } modmul_hs_t;

endpackage

// File: rtl/dh_decrypt_r1_if.sv
// Request/response bundle between the initiator and the dh_decrypt_r1 responder.
interface dh_decrypt_r1_if
  import dh_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int KW = DEF_KW
);
  logic          start;
  logic [DW-1:0] base;
  logic [DW-1:0] exp;
  logic [DW-1:0] p;
  logic [KW-1:0] r2;
  logic [KW-1:0] c2;
  logic          c2_valid;
  logic          busy;
  logic [KW-1:0] c1;
  logic          c1_valid;
  logic [KW-1:0] r1;
  logic          r1_valid;
  logic          err;

  modport master (
    output start, base, exp, p, r2, c2, c2_valid,
    input  busy, c1, c1_valid, r1, r1_valid, err
  );

  modport slave (
    input  start, base, exp, p, r2, c2, c2_valid,
    output busy, c1, c1_valid, r1, r1_valid, err
  );
endinterface

// File: rtl/dh_modmul.sv
// Iterative interleaved modular multiplier: y = a*b mod p, one multiplier bit per cycle.
// Operands must already be reduced (a, b < p); done pulses DW+1 cycles after start.
module dh_modmul
  import dh_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] p,
  output logic          done,
  output logic [DW-1:0] y
);
  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] a_r;
  logic [DW-1:0] b_r;
  logic [DW-1:0] p_r;
  logic [DW:0]   acc_r;
  logic [CW-1:0] cnt_r;
  logic          run_r;
  logic [DW:0]   dbl_s;
  logic [DW:0]   red1_s;
  logic [DW:0]   add_s;
  logic [DW:0]   red2_s;

  // One step: acc = (2*acc + b_msb*a) mod p, each partial sum stays below 2p.
  always_comb begin
    dbl_s = acc_r << 1;
    if (dbl_s >= {1'b0, p_r}) red1_s = dbl_s - {1'b0, p_r};
    else                      red1_s = dbl_s;
    if (b_r[DW-1]) add_s = red1_s + {1'b0, a_r};
    else           add_s = red1_s;
    if (add_s >= {1'b0, p_r}) red2_s = add_s - {1'b0, p_r};
    else                      red2_s = add_s;
  end

  // Operand capture, step sequencing and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r   <= '0;
      b_r   <= '0;
      p_r   <= '0;
      acc_r <= '0;
      cnt_r <= '0;
      run_r <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
    end else begin
      done <= 1'b0;
      if (run_r) begin
        if (cnt_r == '0) begin
          done  <= 1'b1;
          y     <= acc_r[DW-1:0];
          run_r <= 1'b0;
        end else begin
          acc_r <= red2_s;
          b_r   <= b_r << 1;
          cnt_r <= cnt_r - 1'b1;
        end
      end else if (start) begin
        a_r   <= a;
        b_r   <= b;
        p_r   <= p;
        acc_r <= '0;
        cnt_r <= CW'(DW);
        run_r <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/dh_decrypt_r1.sv
// DH responder: k = base^exp mod p, sends c1 = k^r2, recovers r1 = k^c2.
// Optional WAIT_C2 timeout enabled by defining DH_TIMEOUT_EN.
module dh_decrypt_r1
  import dh_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int KW      = DEF_KW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic             clk,
  input logic             rst,
  dh_decrypt_r1_if.slave  bus
);
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;

  if (KW > DW || TIMEOUT < 1) begin : g_cfg_check
    $error("dh_decrypt_r1: KW must not exceed DW and TIMEOUT must be positive");
  end

  dh_state_t     state_r;
  logic [DW-1:0] base_r;
  logic [DW-1:0] exp_r;
  logic [DW-1:0] p_r;
  logic [DW-1:0] acc_r;
  logic [KW-1:0] r2_r;
  logic [IW-1:0] idx_r;
  logic          mm_start_r;
  logic          mm_pend_r;
  logic          mm_done_s;
  logic [DW-1:0] mm_b_s;
  logic [DW-1:0] mm_y_s;
  modmul_hs_t    mm_hs_s;
  logic          busy_r;
  logic [KW-1:0] c1_r;
  logic          c1_valid_r;
  logic [KW-1:0] r1_r;
  logic          r1_valid_r;
  logic          err_r;
`ifdef DH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_r;
`endif

  assign mm_hs_s = '{start: mm_start_r, done: mm_done_s};
  assign mm_b_s  = (state_r == MUL) ? base_r : acc_r;

  dh_modmul #(.DW(DW)) u_modmul (
    .clk   (clk),
    .rst   (rst),
    .start (mm_hs_s.start),
    .a     (acc_r),
    .b     (mm_b_s),
    .p     (p_r),
    .done  (mm_done_s),
    .y     (mm_y_s)
  );

  assign bus.busy     = busy_r;
  assign bus.c1       = c1_r;
  assign bus.c1_valid = c1_valid_r;
  assign bus.r1       = r1_r;
  assign bus.r1_valid = r1_valid_r;
  assign bus.err      = err_r;

  // Exchange sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      base_r     <= '0;
      exp_r      <= '0;
      p_r        <= '0;
      acc_r      <= '0;
      r2_r       <= '0;
      idx_r      <= '0;
      mm_start_r <= 1'b0;
      mm_pend_r  <= 1'b0;
      busy_r     <= 1'b0;
      c1_r       <= '0;
      c1_valid_r <= 1'b0;
      r1_r       <= '0;
      r1_valid_r <= 1'b0;
      err_r      <= 1'b0;
`ifdef DH_TIMEOUT_EN
      tmo_r      <= '0;
`endif
    end else begin
      mm_start_r <= 1'b0;
      r1_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            base_r  <= bus.base;
            exp_r   <= bus.exp;
            p_r     <= bus.p;
            r2_r    <= bus.r2;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= CHECK;
          end
        end
        CHECK: begin
          if (p_r < DW'(2) || base_r >= p_r) begin
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            acc_r   <= DW'(1);
            idx_r   <= IW'(DW - 1);
            state_r <= SQR;
          end
        end
        SQR, MUL: begin
          // Launch the multiplier once per visit, then wait for its result.
          if (!mm_pend_r) begin
            mm_start_r <= 1'b1;
            mm_pend_r  <= 1'b1;
          end else if (mm_hs_s.done) begin
            acc_r     <= mm_y_s;
            mm_pend_r <= 1'b0;
            state_r   <= (state_r == SQR && exp_r[idx_r]) ? MUL : NEXT;
          end
        end
        NEXT: begin
          if (idx_r == '0) begin
            state_r <= SEND_C1;
          end else begin
            idx_r   <= idx_r - 1'b1;
            state_r <= SQR;
          end
        end
        SEND_C1: begin
          c1_r       <= acc_r[KW-1:0] ^ r2_r;
          c1_valid_r <= 1'b1;
`ifdef DH_TIMEOUT_EN
          tmo_r      <= '0;
`endif
          state_r    <= WAIT_C2;
        end
        WAIT_C2: begin
          if (bus.c2_valid) begin
            r1_r       <= acc_r[KW-1:0] ^ bus.c2;
            r1_valid_r <= 1'b1;
            c1_valid_r <= 1'b0;
            state_r    <= DONE;
          end
`ifdef DH_TIMEOUT_EN
          else if (tmo_r == TW'(TIMEOUT - 1)) begin
            err_r      <= 1'b1;
            c1_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
`endif
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r     <= 1'b0;
          c1_valid_r <= 1'b0;
          mm_pend_r  <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dh_decrypt_r1.sv
// Directed bench for dh_decrypt_r1 at DW=8, KW=4, TIMEOUT=16.
module tb_dh_decrypt_r1;
  import dh_pkg::*;

  localparam int DW = 8;
  localparam int KW = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;

  dh_decrypt_r1_if #(.DW(DW), .KW(KW)) bus ();

  dh_decrypt_r1 #(.DW(DW), .KW(KW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [DW-1:0] b, input logic [DW-1:0] e,
                          input logic [DW-1:0] pp, input logic [KW-1:0] rr);
    @(negedge clk);
    bus.start = 1'b1; bus.base = b; bus.exp = e; bus.p = pp; bus.r2 = rr;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_c1(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge clk);
      ok = bus.c1_valid;
    end
  endtask

  // Drives one c2 beat; returns at the negedge inside DONE.
  task automatic send_c2(input logic [KW-1:0] v);
    bus.c2 = v; bus.c2_valid = 1'b1;
    @(negedge clk);
    bus.c2_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.base = '0; bus.exp = '0; bus.p = '0;
    bus.r2 = '0; bus.c2 = '0; bus.c2_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.c1_valid !== 1'b0 || bus.r1_valid !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got c1v=%b r1v=%b err=%b want 0", bus.c1_valid, bus.r1_valid, bus.err); end
    checks++; if (bus.c1 !== 4'h0 || bus.r1 !== 4'h0) begin
      errors++; $display("FAIL reset_data got c1=%h r1=%h want 0", bus.c1, bus.r1); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    do_start(8'd8, 8'd6, 8'd23, 4'h5);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bus.busy); end
    wait_c1(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_c1_timeout got no c1_valid want c1_valid"); end
    checks++; if (bus.c1 !== 4'h8) begin errors++; $display("FAIL basic_c1 got %h want 8", bus.c1); end
    repeat (3) @(negedge clk);
    checks++; if (bus.c1_valid !== 1'b1 || bus.c1 !== 4'h8) begin
      errors++; $display("FAIL basic_c1_hold got c1v=%b c1=%h want 1/8", bus.c1_valid, bus.c1); end
    send_c2(4'hE);
    checks++; if (bus.r1_valid !== 1'b1 || bus.r1 !== 4'h3) begin
      errors++; $display("FAIL basic_r1 got r1v=%b r1=%h want 1/3", bus.r1_valid, bus.r1); end
    checks++; if (bus.c1_valid !== 1'b0) begin errors++; $display("FAIL basic_c1_drop got %b want 0", bus.c1_valid); end
    @(negedge clk);
    checks++; if (bus.r1_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle got r1v=%b busy=%b want 0/0", bus.r1_valid, bus.busy); end
    checks++; if (bus.r1 !== 4'h3 || bus.c1 !== 4'h8) begin
      errors++; $display("FAIL basic_hold got r1=%h c1=%h want 3/8", bus.r1, bus.c1); end
  endtask

  task automatic test_exp_zero();
    bit ok;
    do_start(8'd8, 8'd0, 8'd23, 4'hA);
    wait_c1(ok);
    checks++; if (!ok || bus.c1 !== 4'hB) begin
      errors++; $display("FAIL exp0_c1 got ok=%b c1=%h want 1/b", ok, bus.c1); end
    send_c2(4'h1);
    checks++; if (bus.r1 !== 4'h0 || bus.r1_valid !== 1'b1) begin
      errors++; $display("FAIL exp0_r1 got r1v=%b r1=%h want 1/0", bus.r1_valid, bus.r1); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [DW-1:0] eb [4] = '{8'd30, 8'd0, 8'd0, 8'd23};
    logic [DW-1:0] ep [4] = '{8'd23, 8'd1, 8'd0, 8'd23};
    bit ok;
    bit seen;
    for (int t = 0; t < 4; t++) begin
      do_start(eb[t], 8'd1, ep[t], 4'h0);
      @(negedge clk);
      checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL err_case%0d got err=%b busy=%b want 1/0", t, bus.err, bus.busy); end
      seen = 1'b0;
      repeat (5) begin @(negedge clk); seen = seen | bus.c1_valid; end
      checks++; if (seen !== 1'b0 || bus.err !== 1'b1) begin
        errors++; $display("FAIL err_quiet%0d got c1v_seen=%b err=%b want 0/1", t, seen, bus.err); end
    end
    do_start(8'd1, 8'd5, 8'd2, 4'h7);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", bus.err); end
    wait_c1(ok);
    checks++; if (!ok || bus.c1 !== 4'h6 || bus.err !== 1'b0) begin
      errors++; $display("FAIL err_p2_c1 got ok=%b c1=%h err=%b want 1/6/0", ok, bus.c1, bus.err); end
    send_c2(4'h7);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(8'd8, 8'd6, 8'd23, 4'h5);
    repeat (6) @(negedge clk);
    checks++; if (dut.state_r !== SQR) begin errors++; $display("FAIL rstmid_pre got state=%0d want SQR", dut.state_r); end
    rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.c1 !== 4'h0 || bus.r1 !== 4'h0 || bus.err !== 1'b0 || bus.c1_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_out got busy=%b c1=%h r1=%h err=%b c1v=%b want 0", bus.busy, bus.c1, bus.r1, bus.err, bus.c1_valid); end
    checks++; if (dut.state_r !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d want IDLE", dut.state_r); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.r1_valid !== 1'b0 || bus.c1_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet got r1v=%b c1v=%b busy=%b want 0", bus.r1_valid, bus.c1_valid, bus.busy); end
    do_start(8'd5, 8'd3, 8'd23, 4'hF);
    wait_c1(ok);
    checks++; if (!ok || bus.c1 !== 4'h5) begin errors++; $display("FAIL rstmid_c1 got ok=%b c1=%h want 1/5", ok, bus.c1); end
    send_c2(4'h0);
    checks++; if (bus.r1 !== 4'hA) begin errors++; $display("FAIL rstmid_r1 got %h want a", bus.r1); end
    @(negedge clk);
  endtask

  task automatic test_ignored();
    bit ok;
    do_start(8'd8, 8'd6, 8'd23, 4'h5);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.base = 8'd5; bus.exp = 8'd3; bus.r2 = 4'hF;
    bus.c2 = 4'h0; bus.c2_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.c2_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.r1_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL ign_stray got r1v=%b busy=%b want 0/1", bus.r1_valid, bus.busy); end
    wait_c1(ok);
    checks++; if (!ok || bus.c1 !== 4'h8) begin errors++; $display("FAIL ign_c1 got ok=%b c1=%h want 1/8", ok, bus.c1); end
    send_c2(4'hE);
    checks++; if (bus.r1 !== 4'h3 || bus.r1_valid !== 1'b1) begin
      errors++; $display("FAIL ign_r1 got r1v=%b r1=%h want 1/3", bus.r1_valid, bus.r1); end
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [DW-1:0] vb [3] = '{8'd22, 8'd250, 8'd2};
    logic [DW-1:0] ve [3] = '{8'd255, 8'd3, 8'd10};
    logic [DW-1:0] vp [3] = '{8'd23, 8'd251, 8'd23};
    logic [KW-1:0] vr [3] = '{4'h0, 4'h3, 4'h3};
    logic [KW-1:0] vc [3] = '{4'h9, 4'hC, 4'hC};
    logic [KW-1:0] xc1 [3] = '{4'h6, 4'h9, 4'hF};
    logic [KW-1:0] xr1 [3] = '{4'hF, 4'h6, 4'h0};
    bit ok;
    for (int t = 0; t < 3; t++) begin
      do_start(vb[t], ve[t], vp[t], vr[t]);
      wait_c1(ok);
      checks++; if (!ok || bus.c1 !== xc1[t]) begin
        errors++; $display("FAIL vec%0d_c1 got ok=%b c1=%h want 1/%h", t, ok, bus.c1, xc1[t]); end
      send_c2(vc[t]);
      checks++; if (bus.r1 !== xr1[t]) begin
        errors++; $display("FAIL vec%0d_r1 got %h want %h", t, bus.r1, xr1[t]); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_start(8'd8, 8'd6, 8'd23, 4'h5);
    wait_c1(ok);
`ifdef DH_TIMEOUT_EN
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++; if (!ok || bus.c1_valid !== 1'b1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL tmo_last got ok=%b c1v=%b err=%b want 1/1/0", ok, bus.c1_valid, bus.err); end
    @(negedge clk);
    checks++; if (bus.err !== 1'b1 || bus.c1_valid !== 1'b0 || bus.busy !== 1'b0 || bus.r1_valid !== 1'b0) begin
      errors++; $display("FAIL tmo_expire got err=%b c1v=%b busy=%b r1v=%b want 1/0/0/0", bus.err, bus.c1_valid, bus.busy, bus.r1_valid); end
    do_start(8'd8, 8'd6, 8'd23, 4'h5);
    wait_c1(ok);
    repeat (TIMEOUT - 1) @(negedge clk);
    send_c2(4'hE);
    checks++; if (!ok || bus.r1_valid !== 1'b1 || bus.r1 !== 4'h3 || bus.err !== 1'b0) begin
      errors++; $display("FAIL tmo_race got ok=%b r1v=%b r1=%h err=%b want 1/1/3/0", ok, bus.r1_valid, bus.r1, bus.err); end
    @(negedge clk);
`else
    repeat (3 * TIMEOUT) @(negedge clk);
    checks++; if (!ok || bus.c1_valid !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL nowait_hold got ok=%b c1v=%b err=%b busy=%b want 1/1/0/1", ok, bus.c1_valid, bus.err, bus.busy); end
    send_c2(4'hE);
    checks++; if (bus.r1_valid !== 1'b1 || bus.r1 !== 4'h3) begin
      errors++; $display("FAIL nowait_r1 got r1v=%b r1=%h want 1/3", bus.r1_valid, bus.r1); end
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exp_zero();
    test_errors();
    test_reset_mid();
    test_ignored();
    test_vectors();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dh_decrypt_r1.md
Name: dh_decrypt_r1

Overview:
- Responder-side partner of the R1 encryption stage in the Diffie-Hellman exchange.
- Computes shared secret k = base^exp mod p sequentially (square-and-multiply over an iterative modular multiplier).
- Encrypts its own nonce r2 as c1 = k[KW-1:0] ^ r2 and hands c1 to the initiator.
- Waits for the initiator's c2 and recovers r1 = k[KW-1:0] ^ c2.

Parameters:
- DW, 32, width of base, exp, p and the internal accumulator.
- KW, 4, width of nonces r1/r2 and ciphertexts c1/c2; k is truncated to its low KW bits.
- TIMEOUT, 1024, WAIT_C2 cycle limit; used only with DH_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request; sampled only in IDLE
- base  input  DW  initiator public value; captured on accepted start
- exp  input  DW  responder secret exponent; captured on accepted start
- p  input  DW  modulus; captured on accepted start
- r2  input  KW  responder nonce; captured on accepted start
- c2  input  KW  ciphertext from initiator
- c2_valid  input  1  c2 qualifier; sampled only in WAIT_C2
- busy  output  1  high in every state except IDLE
- c1  output  KW  encrypted r2
- c1_valid  output  1  level, high throughout WAIT_C2
- r1  output  KW  recovered initiator nonce
- r1_valid  output  1  one-cycle pulse
- err  output  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, all registers 0. Reset mid-operation aborts immediately; no output pulses follow.
- Accepted start (IDLE & start):
  - Capture base, exp, p and r2; clear err.
  - Go to CHECK.
- CHECK (1 cycle):
  - If p<2 or base>=p: set err=1 and return to IDLE; c1_valid never asserts.
  - Otherwise set acc=1, bit index i=DW-1 and go to SQR.
- SQR: acc = acc*acc mod p via sub-module.
  - Then go to MUL if exp[i]=1, else to NEXT.
- MUL: acc = acc*base mod p via sub-module; then NEXT.
- NEXT (1 cycle): if i==0 go to SEND_C1, else decrement i and go to SQR.
- exp=0 yields k=1.
- SEND_C1 (1 cycle): c1 <= acc[KW-1:0] ^ r2_q; go to WAIT_C2.
- WAIT_C2:
  - c1_valid=1 and c1 stays stable.
  - On c2_valid: r1 <= acc[KW-1:0] ^ c2; r1_valid pulses next cycle in DONE; c1_valid drops.
- DONE (1 cycle): go to IDLE.
- r1 and c1 hold their values until the next accepted start.
- start while busy: ignored. c2_valid outside WAIT_C2: ignored.
- Modular multiplier handshake:
  - Each start/done pair takes DW+1 cycles: DW interleaved shift-add-reduce steps, then done.
  - Internal width is DW+1 bits, so no overflow.
  - Both operands are always < p.

Optional Feature:
- Macro: DH_TIMEOUT_EN.
- With the macro: a counter runs in WAIT_C2. If TIMEOUT cycles elapse without c2_valid, set err=1, drop c1_valid and return to IDLE without pulsing r1_valid.
- c2_valid on the same cycle the counter expires takes priority; the exchange completes normally.
- Without the macro: WAIT_C2 waits indefinitely and the TIMEOUT parameter is unused.

Decomposition:
- Shared package dh_pkg holds:
  - State enum: IDLE, CHECK, SQR, MUL, NEXT, SEND_C1, WAIT_C2, DONE.
  - Default DW/KW/TIMEOUT constants.
  - Multiplier handshake typedef.
- One sub-module, dh_modmul: parameter DW; ports clk, rst, start, a, b, p, done, y; implements the interleaved modular multiplication.

Test Plan:
- DW=8, base=8, exp=6, p=23, r2=0x5 → k=13, c1=0x8 with c1_valid. Then c2=0xE, c2_valid → r1=0x3 and a one-cycle r1_valid pulse.
- exp=0, p=23, r2=0xA → k=1, c1=0xB.
- p=1, or base=30 with p=23 → err=1 after CHECK, busy low next cycle, c1_valid never asserts. The next valid start clears err.
- Assert rst low during SQR, then release → all outputs 0, state IDLE. A following start completes correctly.
- start pulsed while busy, and c2_valid asserted during SQR → both ignored; result unchanged from the first scenario.
- DH_TIMEOUT_EN with TIMEOUT=16, no c2_valid → err=1 and c1_valid=0 after 16 WAIT_C2 cycles. Repeat with c2_valid on cycle 16 → normal completion.
